// File: rtl/adc_capture_multi_if.sv
// rtl/adc_capture_multi_if.sv - control, sample and status bundle for the N-channel ADC capture block
interface adc_capture_multi_if #(
   parameter int NUM_CH       = 2,
   parameter int DATA_W       = 10,
   parameter int MAX_DEC_LOG2 = 4
);
   localparam int DW = $clog2(MAX_DEC_LOG2 + 1);

   logic                       enable;
   logic [DW-1:0]              dec_log2;
   logic                       fmt_signed;
   logic                       ovr_clear;
   logic [NUM_CH*DATA_W-1:0]   adc_in;
   logic [NUM_CH-1:0]          adc_clk_out;
   logic [NUM_CH*DATA_W-1:0]   data_out;
   logic                       data_valid;
   logic [NUM_CH-1:0]          ovr_flag;

   modport master (
      output enable, dec_log2, fmt_signed, ovr_clear, adc_in,
      input  adc_clk_out, data_out, data_valid, ovr_flag
   );

   modport slave (
      input  enable, dec_log2, fmt_signed, ovr_clear, adc_in,
      output adc_clk_out, data_out, data_valid, ovr_flag
   );
endinterface

// File: rtl/adc_capture_multi.sv
// rtl/adc_capture_multi.sv - N-channel ADC capture with format conversion, boxcar decimation and over-range flags
module adc_capture_multi #(
   parameter int NUM_CH       = 2,
   parameter int DATA_W       = 10,
   parameter int MAX_DEC_LOG2 = 4
) (
   input logic                clk,
   input logic                rst_n,
   adc_capture_multi_if.slave bus
);
   localparam int DW = $clog2(MAX_DEC_LOG2 + 1);
   localparam int CW = (MAX_DEC_LOG2 < 1) ? 1 : MAX_DEC_LOG2;
   localparam int AW = DATA_W + MAX_DEC_LOG2;
   localparam int BW = NUM_CH * DATA_W;

   logic [BW-1:0]     r_d1;
   logic [BW-1:0]     r_d2;
   logic [AW-1:0]     r_acc [NUM_CH];
   logic [CW-1:0]     r_cnt;
   logic [DW-1:0]     r_n_l;
   logic              r_fmt_l;
   logic [BW-1:0]     r_data_out;
   logic              r_data_valid;
   logic [NUM_CH-1:0] r_ovr;

   logic [DW-1:0]     w_n_clamped;
   logic [CW:0]       w_blk_len;
   logic              w_blk_end;
   logic [AW-1:0]     w_sum [NUM_CH];
   logic [BW-1:0]     w_avg;
   logic [NUM_CH-1:0] w_ovr_hit;

   assign w_n_clamped = (bus.dec_log2 > DW'(MAX_DEC_LOG2)) ? DW'(MAX_DEC_LOG2) : bus.dec_log2;
   assign w_blk_len   = (CW+1)'(1) << r_n_l;
   assign w_blk_end   = ({1'b0, r_cnt} == (w_blk_len - 1'b1));

   genvar ch;
   generate
      for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
         logic [DATA_W-1:0] w_raw;
         logic [DATA_W-1:0] w_conv;
         logic [AW-1:0]     w_ext;

         assign w_raw  = r_d2[ch*DATA_W +: DATA_W];
         // Offset-binary to two's complement is just an MSB flip.
         assign w_conv = {w_raw[DATA_W-1] ^ r_fmt_l, w_raw[DATA_W-2:0]};
         assign w_ext  = r_fmt_l ? AW'($signed(w_conv)) : AW'(w_conv);
         assign w_sum[ch] = r_acc[ch] + w_ext;
         // Shifting the full-width sum gives floor division in both formats.
         assign w_avg[ch*DATA_W +: DATA_W] = r_fmt_l ? DATA_W'($signed(w_sum[ch]) >>> r_n_l)
                                                     : DATA_W'(w_sum[ch] >> r_n_l);
         // Rails are judged on the raw code, before any format conversion.
         assign w_ovr_hit[ch] = bus.enable && ((&w_raw) || (~|w_raw));
      end
   endgenerate

   // Free-running two-stage input register, independent of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1 <= '0;
         r_d2 <= '0;
      end else begin
         r_d1 <= bus.adc_in;
         r_d2 <= r_d1;
      end
   end

   // Config is only sampled while idle so a running capture sees fixed settings.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n_l   <= '0;
         r_fmt_l <= 1'b0;
      end else if (!bus.enable) begin
         r_n_l   <= w_n_clamped;
         r_fmt_l <= bus.fmt_signed;
      end
   end

   // Accumulate-and-dump per block; dropping enable discards a partial block but keeps data_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
         r_cnt        <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else if (!bus.enable) begin
         for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
         r_cnt        <= '0;
         r_data_valid <= 1'b0;
      end else if (w_blk_end) begin
         for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
         r_cnt        <= '0;
         r_data_out   <= w_avg;
         r_data_valid <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) r_acc[i] <= w_sum[i];
         r_cnt        <= r_cnt + 1'b1;
         r_data_valid <= 1'b0;
      end
   end

   // Sticky over-range flags; a fresh hit outranks a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovr <= '0;
      end else begin
         r_ovr <= (bus.ovr_clear ? '0 : r_ovr) | w_ovr_hit;
      end
   end

   assign bus.adc_clk_out = {NUM_CH{clk}};
   assign bus.data_out    = r_data_out;
   assign bus.data_valid  = r_data_valid;
   assign bus.ovr_flag    = r_ovr;
endmodule

// File: tb/tb_adc_capture_multi.sv
// tb/tb_adc_capture_multi.sv - self-checking bench for adc_capture_multi
module tb_adc_capture_multi;
   localparam int NUM_CH = 2;
   localparam int DATA_W = 10;
   localparam int MAXD   = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adc_capture_multi_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DEC_LOG2(MAXD)) bus ();

   adc_capture_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DEC_LOG2(MAXD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: integer sample values, averaged with floor division.
   logic [19:0] m_p1, m_p2, m_out;
   int          m_acc [2];
   int          m_cnt, m_n;
   bit          m_fmt, m_valid;
   logic [1:0]  m_ovr;

   task automatic model_reset();
      m_p1 = '0; m_p2 = '0; m_out = '0; m_acc[0] = 0; m_acc[1] = 0;
      m_cnt = 0; m_n = 0; m_fmt = 0; m_valid = 0; m_ovr = '0;
   endtask

   task automatic model_edge();
      int raw, sv, tot, d, q;
      logic [1:0] hit;
      bit last;
      hit = '0;
      if (bus.enable) begin
         last = (m_cnt == (1 << m_n) - 1);
         for (int c = 0; c < 2; c++) begin
            raw = int'(m_p2[c*10 +: 10]);
            hit[c] = (raw == 0) || (raw == 1023);
            sv = m_fmt ? raw - 512 : raw;
            if (last) begin
               tot = m_acc[c] + sv;
               d = 1 << m_n;
               q = tot / d;
               if (tot < 0 && q * d != tot) q = q - 1;
               m_out[c*10 +: 10] = q[9:0];
               m_acc[c] = 0;
            end else begin
               m_acc[c] = m_acc[c] + sv;
            end
         end
         if (last) begin m_valid = 1; m_cnt = 0; end
         else begin m_valid = 0; m_cnt = m_cnt + 1; end
      end else begin
         m_valid = 0; m_cnt = 0; m_acc[0] = 0; m_acc[1] = 0;
         m_n = (int'(bus.dec_log2) > MAXD) ? MAXD : int'(bus.dec_log2);
         m_fmt = bus.fmt_signed;
      end
      m_ovr = (bus.ovr_clear ? 2'b00 : m_ovr) | hit;
      m_p2 = m_p1;
      m_p1 = bus.adc_in;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.dec_log2 = '0; bus.fmt_signed = 1'b0;
      bus.ovr_clear = 1'b0; bus.adc_in = '0;
      model_reset();
      #3;
      n_checks++; if (bus.data_out !== 20'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", bus.data_out); end
      n_checks++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b exp 0", bus.data_valid); end
      n_checks++; if (bus.ovr_flag !== 2'b00) begin n_fail++; $display("FAIL reset_ovr_flag got %b exp 00", bus.ovr_flag); end
      @(posedge clk); #1;
      n_checks++; if (bus.adc_clk_out !== 2'b11) begin n_fail++; $display("FAIL adc_clk_high got %b exp 11", bus.adc_clk_out); end
      #5;
      n_checks++; if (bus.adc_clk_out !== 2'b00) begin n_fail++; $display("FAIL adc_clk_low got %b exp 00", bus.adc_clk_out); end
      rst_n = 1'b1;
   endtask

   task automatic test_passthrough();
      bus.enable = 1'b0; bus.dec_log2 = 3'd0; bus.fmt_signed = 1'b0;
      bus.adc_in = {10'h155, 10'd5};
      step(); step();
      bus.enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.adc_in = {10'h155, 10'(i)};
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL pass_model i=%0d got v=%b d=%h o=%b exp v=%b d=%h o=%b", i, bus.data_valid, bus.data_out, bus.ovr_flag, m_valid, m_out, m_ovr);
         end
         if (i >= 2) begin
            n_checks++;
            if ({bus.data_valid, bus.data_out} !== {1'b1, 10'h155, 10'(i - 2)}) begin
               n_fail++; $display("FAIL pass_delay i=%0d got v=%b d=%h exp v=1 ch0=%0d ch1=155", i, bus.data_valid, bus.data_out, i - 2);
            end
         end
      end
   endtask

   task automatic test_decimate();
      int pat [4] = '{100, 101, 102, 104};
      bus.enable = 1'b0; bus.dec_log2 = 3'd2; bus.fmt_signed = 1'b0;
      for (int c = 0; c < 18; c++) begin
         bus.adc_in = {10'h155, 10'(pat[c % 4])};
         bus.enable = (c >= 2);
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL dec_model c=%0d got v=%b d=%h exp v=%b d=%h", c, bus.data_valid, bus.data_out, m_valid, m_out);
         end
         if (c >= 2) begin
            n_checks++;
            if ((c - 2) % 4 == 3) begin
               if ({bus.data_valid, bus.data_out} !== {1'b1, 10'h155, 10'd101}) begin
                  n_fail++; $display("FAIL dec_pulse c=%0d got v=%b d=%h exp v=1 d=%h", c, bus.data_valid, bus.data_out, {10'h155, 10'd101});
               end
            end else if (bus.data_valid !== 1'b0) begin
               n_fail++; $display("FAIL dec_gap c=%0d got v=%b exp 0", c, bus.data_valid);
            end
         end
      end
   endtask

   task automatic test_signed();
      logic [9:0] exp0;
      for (int pass = 0; pass < 2; pass++) begin
         bus.enable = 1'b0; bus.dec_log2 = 3'(pass); bus.fmt_signed = 1'b1;
         for (int c = 0; c < 10; c++) begin
            bus.adc_in = {10'h155, ((c % 2) != 0) ? 10'h3FF : 10'h000};
            bus.enable = (c >= 2);
            step();
            n_checks++;
            if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
               n_fail++; $display("FAIL sgn_model n=%0d c=%0d got v=%b d=%h exp v=%b d=%h", pass, c, bus.data_valid, bus.data_out, m_valid, m_out);
            end
            if (c >= 2 && (pass == 0 || (c - 2) % 2 == 1)) begin
               exp0 = (pass == 1) ? 10'h3FF : (((c - 2) % 2 != 0) ? 10'h1FF : 10'h200);
               n_checks++;
               if ({bus.data_valid, bus.data_out[9:0]} !== {1'b1, exp0}) begin
                  n_fail++; $display("FAIL sgn_value n=%0d c=%0d got v=%b ch0=%h exp v=1 ch0=%h", pass, c, bus.data_valid, bus.data_out[9:0], exp0);
               end
            end
         end
      end
   endtask

   task automatic test_overrange();
      bus.enable = 1'b0; bus.dec_log2 = 3'd0; bus.fmt_signed = 1'b0;
      bus.adc_in = {10'h100, 10'h155};
      step(); step();
      bus.ovr_clear = 1'b1; step(); bus.ovr_clear = 1'b0;
      n_checks++; if (bus.ovr_flag !== 2'b00) begin n_fail++; $display("FAIL ovr_cleared got %b exp 00", bus.ovr_flag); end
      bus.enable = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.adc_in = {(c == 2) ? 10'h3FF : ((c == 5) ? 10'h000 : 10'h100), 10'h155};
         bus.ovr_clear = (c == 7 || c == 9);
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL ovr_model c=%0d got o=%b d=%h exp o=%b d=%h", c, bus.ovr_flag, bus.data_out, m_ovr, m_out);
         end
         n_checks++;
         if (bus.ovr_flag[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_ch0 c=%0d got %b exp 0", c, bus.ovr_flag[0]); end
         if (c == 3 || c == 4 || c == 7 || c == 8 || c == 9) begin
            n_checks++;
            if (bus.ovr_flag[1] !== ((c == 3 || c == 9) ? 1'b0 : 1'b1)) begin
               n_fail++; $display("FAIL ovr_ch1 c=%0d got %b exp %b", c, bus.ovr_flag[1], (c == 3 || c == 9) ? 1'b0 : 1'b1);
            end
         end
      end
      bus.ovr_clear = 1'b0;
   endtask

   task automatic test_abort();
      logic [19:0] hold;
      int found;
      bus.enable = 1'b0; bus.dec_log2 = 3'd3; bus.fmt_signed = 1'b0;
      for (int c = 0; c < 2; c++) begin
         bus.adc_in = {10'($urandom_range(1, 1022)), 10'($urandom_range(1, 1022))};
         step();
      end
      bus.enable = 1'b1; bus.dec_log2 = 3'd1;
      for (int c = 0; c < 5; c++) begin
         bus.adc_in = {10'($urandom_range(1, 1022)), 10'($urandom_range(1, 1022))};
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL abort_run c=%0d got v=%b d=%h exp v=%b d=%h", c, bus.data_valid, bus.data_out, m_valid, m_out);
         end
      end
      bus.dec_log2 = 3'd3;
      hold = m_out;
      bus.enable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus.adc_in = {10'($urandom_range(1, 1022)), 10'($urandom_range(1, 1022))};
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out} !== {1'b0, hold}) begin
            n_fail++; $display("FAIL abort_hold c=%0d got v=%b d=%h exp v=0 d=%h", c, bus.data_valid, bus.data_out, hold);
         end
      end
      bus.enable = 1'b1;
      found = 0;
      for (int k = 1; k <= 20 && found == 0; k++) begin
         bus.adc_in = {10'($urandom_range(1, 1022)), 10'($urandom_range(1, 1022))};
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL abort_restart k=%0d got v=%b d=%h exp v=%b d=%h", k, bus.data_valid, bus.data_out, m_valid, m_out);
         end
         if (bus.data_valid === 1'b1) found = k;
      end
      n_checks++;
      if (found != 8) begin n_fail++; $display("FAIL abort_first_valid got edge %0d exp 8", found); end
   endtask

   task automatic test_reset_mid();
      int k1, k2;
      bus.enable = 1'b0; bus.dec_log2 = 3'd2; bus.fmt_signed = 1'b0;
      step(); step();
      bus.enable = 1'b1;
      bus.adc_in = {10'd300, 10'd400};
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== 23'h0) begin
         n_fail++; $display("FAIL rst_async got v=%b d=%h o=%b exp all 0", bus.data_valid, bus.data_out, bus.ovr_flag);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.enable = 1'b0; bus.dec_log2 = 3'd7;
      step(); step();
      bus.enable = 1'b1;
      k1 = 0; k2 = 0;
      for (int k = 1; k <= 40; k++) begin
         bus.adc_in = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
         step();
         n_checks++;
         if ({bus.data_valid, bus.data_out, bus.ovr_flag} !== {m_valid, m_out, m_ovr}) begin
            n_fail++; $display("FAIL clamp_model k=%0d got v=%b d=%h o=%b exp v=%b d=%h o=%b", k, bus.data_valid, bus.data_out, bus.ovr_flag, m_valid, m_out, m_ovr);
         end
         if (bus.data_valid === 1'b1) begin
            if (k1 == 0) k1 = k;
            else if (k2 == 0) k2 = k;
         end
      end
      n_checks++;
      if (k1 != 16 || k2 != 32) begin n_fail++; $display("FAIL clamp_period got pulses at %0d,%0d exp 16,32", k1, k2); end
      bus.enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_decimate();
      test_signed();
      test_overrange();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_capture_multi.md
Name: adc_capture_multi

Overview:
Parametrised N-channel synchronous ADC capture block, the successor to the fixed dual 10-bit capture stage. It samples NUM_CH parallel ADC buses of DATA_W bits through a two-stage input register and optionally converts offset-binary to two's complement. It optionally decimates by 2^n with boxcar averaging and flags over-range samples. It sits between the ADC pins and the FFT/measurement pipeline, and all channels share one clk and one data_valid.

Parameters:
NUM_CH, 2, number of ADC channels (1..8)
DATA_W, 10, ADC sample width in bits (8..16)
MAX_DEC_LOG2, 4, largest decimation exponent; averaging length is up to 2^MAX_DEC_LOG2 samples

Ports:
clk  in  1  ADC sampling clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  capture enable
dec_log2  in  DW=$clog2(MAX_DEC_LOG2+1)  decimation exponent n; values above MAX_DEC_LOG2 clamp to MAX_DEC_LOG2
fmt_signed  in  1  0 = offset-binary output, 1 = two's complement output
ovr_clear  in  1  clears all over-range flags
adc_in  in  NUM_CH*DATA_W  packed raw ADC data, ch0 in LSBs
adc_clk_out  out  NUM_CH  per-channel ADC clock, each bit = clk (combinational)
data_out  out  NUM_CH*DATA_W  packed processed samples, ch0 in LSBs
data_valid  out  1  one-cycle strobe marking a new data_out word
ovr_flag  out  NUM_CH  sticky per-channel over-range flags

Behaviour:
- Reset is asynchronous on rst_n low and clk is the only clock. All registers clear to 0: d1, d2, accumulators, count, data_out, data_valid, ovr_flag, and the latched n and fmt.
- Input pipeline runs free, independent of enable: d1 <= adc_in; d2 <= d1.
- Config latch: while enable=0, on each edge, n_l <= min(dec_log2, MAX_DEC_LOG2) and fmt_l <= fmt_signed. While enable=1 these inputs are ignored, so config changes mid-run have no effect.
- Conversion (combinational, on d2): if fmt_l=1, s = d2 with MSB inverted, treated as signed. Otherwise s = d2, unsigned.
- Accumulator per channel:
  - Width is DATA_W+MAX_DEC_LOG2.
  - In signed mode the accumulator sign-extends s; in unsigned mode it zero-extends s.
- Sample counter: cnt, width MAX_DEC_LOG2 (minimum 1 bit), shared by all channels.
- On each edge with enable=1:
  - if cnt == 2^n_l - 1: data_out[ch] <= (acc[ch] + s[ch]) >> n_l, arithmetic shift in signed mode, keeping the low DATA_W bits. data_valid <= 1, acc <= 0, cnt <= 0.
  - otherwise: acc <= acc + s, cnt <= cnt + 1, data_valid <= 0.
- Rounding is floor (truncation toward -inf). With n_l=0 every enabled edge produces an output.
- Latency: a sample on adc_in at edge k is in d2 after edge k+1 and reaches data_out after edge k+2 when n=0. When n>0, the output appears at the edge on which the 2^n-th sample of the block is in d2.
- Enable low:
  - data_valid <= 0, acc <= 0, cnt <= 0; any partial block is discarded.
  - data_out holds its last value; this deliberately differs from the old zeroing behaviour.
- Enable rise: the first block starts with the d2 value present at the first edge with enable=1.
- Over-range:
  - On any edge with enable=1, if raw d2[ch] is all ones or all zeros, ovr_flag[ch] <= 1.
  - ovr_clear=1 clears all flags. If set and clear occur on the same edge, set wins.
  - Flags are unaffected by enable going low.
- Reset mid-block discards everything. The first valid after reset requires the full pipeline fill plus 2^n_l enabled samples.

Test Plan:
1. NUM_CH=2, DATA_W=10, n=0, fmt=0; ch0 ramps 0..9, ch1 fixed 0x155 -> data_out ch0 equals the adc_in value from 2 edges earlier, ch1 = 0x155; data_valid=1 every cycle from the 3rd enabled edge.
2. n=2, fmt=0; ch0 block inputs 100,101,102,104 -> a single data_valid pulse with ch0 = 101 (407>>2); pulses repeat every 4 cycles; data_out holds between pulses.
3. fmt=1, n=0; input 0x000 -> 0x200 (-512); input 0x3FF -> 0x1FF (+511). Then n=1 with alternating 0x3FF and 0x000 -> output 0x3FF (-1, floor of -0.5).
4. ch1 = 0x3FF for one enabled edge -> ovr_flag[1]=1 and stays set. ovr_clear pulsed on the same edge that ch1 = 0x000 -> flag stays 1. ovr_clear alone -> flag = 0. ch0 flag never sets for mid-range data.
5. n=3; drop enable after 5 samples -> no data_valid and data_out unchanged. Change dec_log2 to 1 while enabled -> ignored. Re-enable -> first pulse after exactly 8 enabled samples, averaged over only the new samples.
6. Assert rst_n low mid-block at n=2 -> all outputs 0 immediately (asynchronous), no stale pulse after release; dec_log2=7 with MAX_DEC_LOG2=4 -> behaves as n=4 (valid every 16 cycles).
